fc_align_supervisor: RTL

Sequencing controller for the fast-command bit-clock aligner. It generates the `fccAlign` request waveform, watches the aligner's state and error outputs, and enforces a timeout. It retries failed alignments up to a configured limit and supervises lock afterwards. It sits in the 40 MHz readout domain beside the aligner and replaces software-driven toggling of `fccAlign`.

---
 rtl/fc_align_supervisor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fc_align_supervisor.sv
// Supervisor for the fast-command bit-clock aligner: drives fccAlign, retries and watches lock.
// Optional FC_ALIGN_AUTO_RELOCK_EN: lock loss re-arms automatically instead of dropping to IDLE.
module fc_align_supervisor #(
  parameter int PULSE_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk40,
  input  logic       rst40,
  input  logic       enable,
  input  logic       start,
  input  logic [3:0] aligner_state,
  input  logic       aligner_error,
  output logic       fccAlign,
  output logic       busy,
  output logic       locked,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] relock_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_PULSE, S_WAIT_START, S_WAIT_DONE,
    S_CHECK, S_RETRY, S_LOCKED, S_FAIL
  } state_t;

  localparam logic [3:0]  PULSE_LAST = 4'(PULSE_LEN - 1);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRIES);
  localparam logic [3:0]  ST_DONE    = 4'd9;

  state_t      state;
  logic [3:0]  phase_cnt;
  logic [15:0] tmo_cnt;
  logic        sweeping;
  logic        done_ok;

  // The aligner's aligned flag is sticky, so lock is judged from its state/error only.
  assign sweeping = (aligner_state != 4'd0) && (aligner_state != ST_DONE);
  assign done_ok  = (aligner_state == ST_DONE) && !aligner_error;

  always_ff @(posedge clk40 or posedge rst40) begin
    if (rst40) begin
      state      <= S_IDLE;
      phase_cnt  <= '0;
      tmo_cnt    <= '0;
      fccAlign   <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      retry_cnt  <= '0;
      relock_cnt <= '0;
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ARM;
            phase_cnt <= '0;
            retry_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        // Two low cycles ahead of the pulse so the aligner sees the 0,0->1 edge.
        S_ARM: begin
          if (phase_cnt == 4'd1) begin
            state     <= S_PULSE;
            phase_cnt <= '0;
            fccAlign  <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        S_PULSE: begin
          if (phase_cnt == PULSE_LAST) begin
            state     <= S_WAIT_START;
            phase_cnt <= '0;
            tmo_cnt   <= '0;
            fccAlign  <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        S_WAIT_START: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (sweeping) begin
            state <= S_WAIT_DONE;
          end else if (phase_cnt == 4'd7) begin
            state <= S_RETRY;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        S_WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (aligner_state == ST_DONE) state <= S_CHECK;
          else if (tmo_cnt == TMO_LAST) state <= S_RETRY;
        end
        S_CHECK: begin
          if (!aligner_error) begin
            state  <= S_LOCKED;
            locked <= 1'b1;
            busy   <= 1'b0;
          end else begin
            state <= S_RETRY;
          end
        end
        S_RETRY: begin
          if (retry_cnt < RETRY_MAX) begin
            state     <= S_ARM;
            phase_cnt <= '0;
            retry_cnt <= retry_cnt + 4'd1;
          end else begin
            state <= S_FAIL;
            fail  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        // A fresh start outranks lock loss in the same cycle.
        S_LOCKED: begin
          if (start) begin
            state     <= S_ARM;
            phase_cnt <= '0;
            retry_cnt <= '0;
            locked    <= 1'b0;
            busy      <= 1'b1;
          end else if (!done_ok) begin
            locked <= 1'b0;
`ifdef FC_ALIGN_AUTO_RELOCK_EN
            state     <= S_ARM;
            phase_cnt <= '0;
            retry_cnt <= '0;
            busy      <= 1'b1;
            if (relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
`else
            state <= S_IDLE;
`endif
          end
        end
        S_FAIL: begin
          if (start) begin
            state     <= S_ARM;
            phase_cnt <= '0;
            retry_cnt <= '0;
            fail      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          fccAlign <= 1'b0;
          busy     <= 1'b0;
          locked   <= 1'b0;
          fail     <= 1'b0;
        end
      endcase
    end
  end

endmodule
